// File: rtl/sfr_array.sv
// sfr_array: parameterised serial-in/parallel-out shift register.
//
// A linear array of WIDTH plain D flip-flops. Each rising edge the register
// either clears, loads a parallel word, shifts one serial bit in (up or
// down), or holds. There is no wrap-around: the bit shifted out is lost.
//
// Ports:
//   i_clk    sole clock, all state changes on the rising edge
//   i_rst_n  synchronous active-low reset, clears every stage
//   i_d      serial data in
//   i_en     shift enable (1 = shift this edge, 0 = hold)
//   i_dir    direction: 0 = up (i_d enters q[0]), 1 = down (i_d enters q[WIDTH-1])
//   i_load   synchronous parallel load strobe, wins over shifting
//   i_pd     parallel load data
//   q        register contents straight from the flip-flops
//   o_so     serial out: the bit the next shift in the current direction discards
module sfr_array #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_d,
  input  logic             i_en,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_pd,
  output logic [WIDTH-1:0] q,
  output logic             o_so
);

  // One storage element per stage, each written by exactly one process.
  logic stage_q [WIDTH];

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_stage
      logic up_in;
      logic down_in;

      // Neighbour wiring: the end stages take the serial input instead of a
      // neighbour, which is what makes the chain open-ended rather than a ring.
      if (i == 0) begin : g_up_first
        assign up_in = i_d;
      end else begin : g_up_mid
        assign up_in = stage_q[i-1];
      end

      if (i == WIDTH-1) begin : g_down_last
        assign down_in = i_d;
      end else begin : g_down_mid
        assign down_in = stage_q[i+1];
      end

      // Priority reset > load > shift > hold; direction is sampled on the
      // same edge it is used, so a direction change costs no bubble.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          stage_q[i] <= 1'b0;
        end else if (i_load) begin
          stage_q[i] <= i_pd[i];
        end else if (i_en) begin
          stage_q[i] <= i_dir ? down_in : up_in;
        end
      end

      assign q[i] = stage_q[i];
    end
  endgenerate

  // Serial out depends only on the flops and the direction select.
  assign o_so = i_dir ? stage_q[0] : stage_q[WIDTH-1];

endmodule

// File: tb/tb_sfr_array.sv
// tb_sfr_array: self-checking bench for sfr_array (WIDTH = 4).
//
// A behavioural model (plain integer arithmetic on a 4-bit word) follows the
// DUT on every rising edge; a compare process checks q and o_so against it
// on every falling edge once the register has been reset. Directed steps
// also pin the model with hand-computed literal values.
module tb_sfr_array;

  localparam int W = 4;
  localparam logic [W-1:0] MASK = 4'hF;

  logic         i_clk;
  logic         i_rst_n;
  logic         i_d;
  logic         i_en;
  logic         i_dir;
  logic         i_load;
  logic [W-1:0] i_pd;
  logic [W-1:0] q;
  logic         o_so;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model;
  logic         model_valid = 1'b0;
  logic         hist_active = 1'b0;
  logic         hist [$];

  sfr_array #(.WIDTH(W)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_d    (i_d),
    .i_en   (i_en),
    .i_dir  (i_dir),
    .i_load (i_load),
    .i_pd   (i_pd),
    .q      (q),
    .o_so   (o_so)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference model: next word computed with shifts/ors on the whole value,
  // plus a history of every bit shifted in upward.
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      model = '0;
      model_valid = 1'b1;
      hist.delete();
    end else if (i_load) begin
      model = i_pd;
    end else if (i_en) begin
      if (i_dir)
        model = (model >> 1) | (W'(i_d) << (W-1));
      else begin
        model = ((model << 1) | W'(i_d)) & MASK;
        if (hist_active) hist.push_back(i_d);
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the rising edge.
  always @(negedge i_clk) begin
    logic exp_so;
    logic [W-1:0] exp_hist;
    if (model_valid) begin
      exp_so = i_dir ? model[0] : model[W-1];
      checks++;
      if (q !== model || o_so !== exp_so) begin
        errors++;
        $display("[TB] FAIL model_cmp t=%0t q=%h so=%b expected q=%h so=%b",
                 $time, q, o_so, model, exp_so);
      end
      if (hist_active && hist.size() >= W) begin
        for (int k = 0; k < W; k++) exp_hist[k] = hist[hist.size()-1-k];
        checks++;
        if (q !== exp_hist) begin
          errors++;
          $display("[TB] FAIL history t=%0t q=%h expected last four bits %h",
                   $time, q, exp_hist);
        end
      end
    end
  end

  // Drive one set of inputs, take one rising edge, return 1 unit after it.
  task automatic applyStimulus(input logic rst_n, input logic load,
                               input logic [W-1:0] pd, input logic en,
                               input logic dir, input logic d);
    i_rst_n = rst_n;
    i_load  = load;
    i_pd    = pd;
    i_en    = en;
    i_dir   = dir;
    i_d     = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [W-1:0] exp_q,
                             input logic exp_so);
    checks++;
    if (q !== exp_q || o_so !== exp_so) begin
      errors++;
      $display("[TB] FAIL %s q=%h so=%b expected q=%h so=%b",
               name, q, o_so, exp_q, exp_so);
    end
  endtask

  logic [W-1:0] up_seq [8] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

  initial begin
    i_rst_n = 1'b0; i_load = 1'b0; i_pd = '0; i_en = 1'b0; i_dir = 1'b0; i_d = 1'b0;

    // Reset clears the register.
    applyStimulus(1'b0, 1'b1, 4'h9, 1'b1, 1'b0, 1'b1);
    checkOutput("reset_init", 4'h0, 1'b0);

    // Load F, then a low pulse between edges must not disturb it.
    applyStimulus(1'b1, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0);
    checkOutput("load_f", 4'hF, 1'b1);
    i_load = 1'b0;
    i_rst_n = 1'b0;
    #2;
    i_rst_n = 1'b1;
    #1;
    checkOutput("async_pulse_ignored", 4'hF, 1'b1);

    // One reset edge from F.
    applyStimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("reset_from_f", 4'h0, 1'b0);

    // Up shift: four ones then four zeros.
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, (k < 4) ? 1'b1 : 1'b0);
      checkOutput($sformatf("up_step%0d", k), up_seq[k], up_seq[k][W-1]);
    end

    // Down shift from zero.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("down_step0", 4'h8, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b1);
    checkOutput("down_step1", 4'hC, 1'b0);

    // Load beats shift; reset beats load.
    applyStimulus(1'b1, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1);
    checkOutput("load_over_shift", 4'hA, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'hA, 1'b1, 1'b0, 1'b1);
    checkOutput("reset_over_load", 4'h0, 1'b0);

    // Hold for three edges with i_d toggling.
    applyStimulus(1'b1, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 1'b0, 4'h0, 1'b0, 1'b0, k[0] ? 1'b0 : 1'b1);
      checkOutput($sformatf("hold%0d", k), 4'h5, 1'b0);
    end

    // Direction change takes effect immediately.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0);
    checkOutput("dir_down", 4'h2, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
    checkOutput("dir_up", 4'h5, 1'b0);

    // Randomised traffic, checked only by the model.
    for (int k = 0; k < 400; k++) begin
      applyStimulus(($urandom_range(0, 19) != 0), ($urandom_range(0, 7) == 0),
                    W'($urandom), ($urandom_range(0, 3) != 0),
                    1'($urandom), 1'($urandom));
    end

    // Periodic serial stream: i_d toggles every 25 units against a 10-unit
    // clock, and q must always hold the last four sampled bits.
    applyStimulus(1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
    hist.delete();
    hist_active = 1'b1;
    fork
      repeat (16) #25 i_d = ~i_d;
      repeat (40) @(posedge i_clk);
    join
    #1;
    hist_active = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
